// File: rtl/fixu_arb.sv
// fixu_arb: round-robin arbiter that shares one fixu among NREQ toggle-handshake requesters.
// One grant at a time: latch operands, toggle fix_req, return z/overflow to the grantee.
module fixu_arb #(
    parameter int NREQ = 4,
    parameter int WID  = 16,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                enable,
    input  logic [NREQ-1:0]     cli_req,
    input  logic [NREQ-1:0]     cli_fn,
    input  logic [NREQ*WID-1:0] cli_a,
    input  logic [NREQ*WID-1:0] cli_b,
    input  logic [NREQ*WID-1:0] cli_c,
    output logic [NREQ-1:0]     cli_ack,
    output logic [NREQ*WID-1:0] cli_z,
    output logic [NREQ-1:0]     cli_overflow,
    output logic                fix_req,
    output logic                fix_fn,
    output logic [WID-1:0]      fix_a,
    output logic [WID-1:0]      fix_b,
    output logic [WID-1:0]      fix_c,
    input  logic                fix_ack,
    input  logic [WID-1:0]      fix_z,
    input  logic                fix_overflow,
    output logic                busy,
    output logic [IW-1:0]       gnt_idx
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state_reg, state_next;
    logic [NREQ-1:0]   ack_reg, ack_next;
    logic [NREQ-1:0]   ov_reg, ov_next;
    logic [WID-1:0]    z_reg [NREQ];
    logic [WID-1:0]    z_next [NREQ];
    logic              fix_req_reg, fix_req_next;
    logic              fix_fn_reg, fix_fn_next;
    logic [WID-1:0]    fix_a_reg, fix_a_next;
    logic [WID-1:0]    fix_b_reg, fix_b_next;
    logic [WID-1:0]    fix_c_reg, fix_c_next;
    logic              busy_reg, busy_next;
    logic [IW-1:0]     gnt_reg, gnt_next;
    logic              ack_seen_reg, ack_seen_next;

    logic [NREQ-1:0]   pend;
    logic [NREQ-1:0]   gsel;
    logic [WID-1:0]    op_a [NREQ];
    logic [WID-1:0]    op_b [NREQ];
    logic [WID-1:0]    op_c [NREQ];
    logic [IW-1:0]     rr_idx [NREQ];
    logic [IW-1:0]     winner;

    // rr_idx[gi] is the requester gi+1 places after the last grantee, modulo NREQ
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cli
            logic [IW:0] sum;
            assign pend[gi] = cli_req[gi] ^ ack_reg[gi];
            assign gsel[gi] = (gnt_reg == IW'(gi));
            assign op_a[gi] = cli_a[gi*WID +: WID];
            assign op_b[gi] = cli_b[gi*WID +: WID];
            assign op_c[gi] = cli_c[gi*WID +: WID];
            assign cli_z[gi*WID +: WID] = z_reg[gi];
            assign sum = {1'b0, gnt_reg} + (IW+1)'(gi + 1);
            assign rr_idx[gi] = (sum >= (IW+1)'(NREQ)) ? IW'(sum - (IW+1)'(NREQ)) : IW'(sum);
        end
    endgenerate

    // Scan farthest-first so the nearest pending requester wins
    always_comb begin
        winner = gnt_reg;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (pend[rr_idx[k]]) begin
                winner = rr_idx[k];
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        ack_next      = ack_reg;
        ov_next       = ov_reg;
        z_next        = z_reg;
        fix_req_next  = fix_req_reg;
        fix_fn_next   = fix_fn_reg;
        fix_a_next    = fix_a_reg;
        fix_b_next    = fix_b_reg;
        fix_c_next    = fix_c_reg;
        busy_next     = busy_reg;
        gnt_next      = gnt_reg;
        // Tracking fix_ack every cycle also resyncs a stray ack seen outside WAIT
        ack_seen_next = fix_ack;
        case (state_reg)
            IDLE: begin
                if (|pend) begin
                    fix_fn_next = cli_fn[winner];
                    fix_a_next  = op_a[winner];
                    fix_b_next  = op_b[winner];
                    fix_c_next  = op_c[winner];
                    gnt_next    = winner;
                    busy_next   = 1'b1;
                    state_next  = ISSUE;
                end
            end
            ISSUE: begin
                fix_req_next = ~fix_req_reg;
                state_next   = WAIT;
            end
            WAIT: begin
                if (fix_ack != ack_seen_reg) begin
                    for (int i = 0; i < NREQ; i++) begin
                        if (gsel[i]) begin
                            z_next[i]   = fix_z;
                            ov_next[i]  = fix_overflow;
                            ack_next[i] = ~ack_reg[i];
                        end
                    end
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg    <= IDLE;
            ack_reg      <= '0;
            ov_reg       <= '0;
            z_reg        <= '{default: '0};
            fix_req_reg  <= 1'b0;
            fix_fn_reg   <= 1'b0;
            fix_a_reg    <= '0;
            fix_b_reg    <= '0;
            fix_c_reg    <= '0;
            busy_reg     <= 1'b0;
            gnt_reg      <= IW'(NREQ - 1);
            ack_seen_reg <= 1'b0;
        end else if (enable) begin
            state_reg    <= state_next;
            ack_reg      <= ack_next;
            ov_reg       <= ov_next;
            z_reg        <= z_next;
            fix_req_reg  <= fix_req_next;
            fix_fn_reg   <= fix_fn_next;
            fix_a_reg    <= fix_a_next;
            fix_b_reg    <= fix_b_next;
            fix_c_reg    <= fix_c_next;
            busy_reg     <= busy_next;
            gnt_reg      <= gnt_next;
            ack_seen_reg <= ack_seen_next;
        end
    end

    assign cli_ack      = ack_reg;
    assign cli_overflow = ov_reg;
    assign fix_req      = fix_req_reg;
    assign fix_fn       = fix_fn_reg;
    assign fix_a        = fix_a_reg;
    assign fix_b        = fix_b_reg;
    assign fix_c        = fix_c_reg;
    assign busy         = busy_reg;
    assign gnt_idx      = gnt_reg;

endmodule

// File: tb/tb_fixu_arb.sv
// tb_fixu_arb: fixu_arb bench with a behavioural fixu (Q5.10) and a queue/array round-robin model.
`timescale 1ns/1ps
module tb_fixu_arb;
    localparam int NREQ = 4;
    localparam int WID  = 16;
    localparam int IW   = 2;
    localparam int FRAC = 10;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic                enable = 1'b1;
    logic [NREQ-1:0]     cli_req = '0;
    logic [NREQ-1:0]     cli_fn = '0;
    logic [NREQ*WID-1:0] cli_a = '0;
    logic [NREQ*WID-1:0] cli_b = '0;
    logic [NREQ*WID-1:0] cli_c = '0;
    logic [NREQ-1:0]     cli_ack;
    logic [NREQ*WID-1:0] cli_z;
    logic [NREQ-1:0]     cli_overflow;
    logic                fix_req;
    logic                fix_fn;
    logic [WID-1:0]      fix_a, fix_b, fix_c;
    logic                fix_ack = 1'b0;
    logic [WID-1:0]      fix_z = '0;
    logic                fix_overflow = 1'b0;
    logic                busy;
    logic [IW-1:0]       gnt_idx;

    fixu_arb #(.NREQ(NREQ), .WID(WID)) dut (
        .clk(clk), .rstn(rstn), .enable(enable),
        .cli_req(cli_req), .cli_fn(cli_fn), .cli_a(cli_a), .cli_b(cli_b), .cli_c(cli_c),
        .cli_ack(cli_ack), .cli_z(cli_z), .cli_overflow(cli_overflow),
        .fix_req(fix_req), .fix_fn(fix_fn), .fix_a(fix_a), .fix_b(fix_b), .fix_c(fix_c),
        .fix_ack(fix_ack), .fix_z(fix_z), .fix_overflow(fix_overflow),
        .busy(busy), .gnt_idx(gnt_idx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // model state
    logic [NREQ-1:0] exp_ack = '0;
    logic [NREQ-1:0] exp_ov = '0;
    logic [WID-1:0]  exp_z [NREQ] = '{default: '0};
    logic [NREQ-1:0] outst_p = '0;
    int   last = NREQ - 1;
    int   cur = 0;
    bit   mdl_busy = 0, issue_due = 0, ack_due = 0;
    bit   rstn_p = 0, en_p = 1;
    logic fr_exp = 1'b0;
    logic fixu_seen = 1'b0;
    bit   counting = 0;
    int   lat = 0;
    int   gnt_log[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WID-1:0] sl(input logic [NREQ*WID-1:0] v, input int i);
        return v[i*WID +: WID];
    endfunction

    // Reference fixu: signed Q5.10; fn0 = a*b+c, fn1 = (a-b)/c; divide by zero flags overflow
    function automatic void fixu_calc(input logic fn, input logic [WID-1:0] a, input logic [WID-1:0] b,
                                      input logic [WID-1:0] c, output logic [WID-1:0] z, output logic ov);
        longint sa, sb, sc, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sc = longint'($signed(c));
        if (!fn) begin
            r = ((sa * sb) >>> FRAC) + sc;
        end else if (sc == 0) begin
            z = '0;
            ov = 1'b1;
            return;
        end else begin
            r = ((sa - sb) * (64'sd1 <<< FRAC)) / sc;
        end
        ov = (r > 32767) || (r < -32768);
        z = r[WID-1:0];
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] p, input int from);
        for (int k = 1; k <= NREQ; k++) begin
            if (p[(from + k) % NREQ]) return (from + k) % NREQ;
        end
        return -1;
    endfunction

    // Monitor + fixu model: everything observed on the falling edge
    always @(negedge clk) begin
        logic [WID-1:0] ez;
        logic eov;
        bit was_idle;
        int w;
        if (!rstn_p) begin
            exp_ack = '0; exp_ov = '0;
            for (int i = 0; i < NREQ; i++) exp_z[i] = '0;
            last = NREQ - 1; mdl_busy = 0; issue_due = 0; ack_due = 0;
            fr_exp = 1'b0; fixu_seen = 1'b0; counting = 0;
            fix_ack = 1'b0; fix_z = '0; fix_overflow = 1'b0;
            chk("rst_fix_ops", 64'({fix_fn, fix_a, fix_b, fix_c}), 64'(0));
        end else if (en_p) begin
            was_idle = !mdl_busy;
            if (issue_due) begin
                fr_exp = ~fr_exp;
                issue_due = 0;
            end
            if (ack_due) begin
                fixu_calc(cli_fn[cur], sl(cli_a, cur), sl(cli_b, cur), sl(cli_c, cur), ez, eov);
                exp_ack[cur] = ~exp_ack[cur];
                exp_z[cur] = ez;
                exp_ov[cur] = eov;
                mdl_busy = 0;
                ack_due = 0;
                $display("done client %0d fn=%0d z=%h ov=%0d", cur, cli_fn[cur], ez, eov);
            end
            if (was_idle && outst_p != '0) begin
                w = rr_pick(outst_p, last);
                gnt_log.push_back(int'(gnt_idx));
                chk("grant_ops", 64'({fix_fn, fix_a, fix_b, fix_c}),
                    64'({cli_fn[w], sl(cli_a, w), sl(cli_b, w), sl(cli_c, w)}));
                last = w; cur = w; mdl_busy = 1; issue_due = 1;
            end
            if (counting) begin
                lat--;
                if (lat == 0) begin
                    counting = 0;
                    fixu_calc(fix_fn, fix_a, fix_b, fix_c, ez, eov);
                    fix_z = ez;
                    fix_overflow = eov;
                    fix_ack = ~fix_ack;
                    ack_due = 1;
                end
            end
            if (fix_req != fixu_seen) begin
                fixu_seen = fix_req;
                lat = $urandom_range(1, 4);
                counting = 1;
            end
        end
        chk("busy", 64'(busy), 64'(mdl_busy));
        chk("gnt_idx", 64'(gnt_idx), 64'(last));
        chk("fix_req", 64'(fix_req), 64'(fr_exp));
        chk("cli_ack", 64'(cli_ack), 64'(exp_ack));
        chk("cli_overflow", 64'(cli_overflow), 64'(exp_ov));
        for (int i = 0; i < NREQ; i++) chk("cli_z", 64'(sl(cli_z, i)), 64'(exp_z[i]));
        outst_p = cli_req ^ exp_ack;
        rstn_p = rstn;
        en_p = enable;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic post(input int i, input logic fn, input logic [WID-1:0] a,
                        input logic [WID-1:0] b, input logic [WID-1:0] c);
        cli_fn[i] = fn;
        cli_a[i*WID +: WID] = a;
        cli_b[i*WID +: WID] = b;
        cli_c[i*WID +: WID] = c;
        cli_req[i] = ~cli_req[i];
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (((cli_req ^ exp_ack) != '0 || mdl_busy) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 64'(n < budget), 64'(1));
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        cli_req = '0;
        repeat (3) tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic chk_log(input string tag, input int n, input int first);
        chk({tag, "_cnt"}, 64'(gnt_log.size()), 64'(n));
        for (int k = 0; k < n && k < gnt_log.size(); k++)
            chk({tag, "_order"}, 64'(gnt_log[k]), 64'((first + k) % NREQ));
    endtask

    initial begin
        logic fr0;
        int n;
        repeat (3) tick();
        rstn = 1'b1;
        tick();

        // single mac request: fix_req toggles 2 cycles after cli_req
        fr0 = fix_req;
        post(0, 1'b0, 16'h0600, 16'h0800, 16'h0400);
        n = 0;
        do begin
            tick();
            n++;
        end while (fix_req == fr0 && n < 10);
        chk("t1_req_lat", 64'(n), 64'(2));
        wait_idle("t1_done", 50);
        chk("t1_z", 64'(sl(cli_z, 0)), 64'h1000);
        chk("t1_ov", 64'(cli_overflow[0]), 64'(0));

        // divide, then divide by zero
        post(1, 1'b1, 16'h0C00, 16'h0400, 16'h0800);
        wait_idle("t2_done", 50);
        chk("t2_z", 64'(sl(cli_z, 1)), 64'h0400);
        chk("t2_ov", 64'(cli_overflow[1]), 64'(0));
        post(1, 1'b1, 16'h0C00, 16'h0400, 16'h0000);
        wait_idle("t2b_done", 50);
        chk("t2b_ov", 64'(cli_overflow[1]), 64'(1));

        // all four at once, two rounds, from a fresh reset
        do_reset();
        for (int r = 0; r < 2; r++) begin
            gnt_log.delete();
            for (int i = 0; i < NREQ; i++)
                post(i, 1'(i & 1), WID'($urandom), WID'($urandom_range(0, 16'h0FFF)), WID'($urandom_range(1, 16'h0FFF)));
            wait_idle("t3_done", 100);
            chk_log("t3", 4, 0);
            chk("t3_acks", 64'(cli_ack), (r == 0) ? 64'hF : 64'h0);
        end

        // client 2 served, then 0 and 3 together -> 3 before 0
        post(2, 1'b0, 16'h0400, 16'h0400, 16'h0000);
        wait_idle("t4a_done", 50);
        gnt_log.delete();
        post(0, 1'b0, 16'h0200, 16'h0200, 16'h0100);
        post(3, 1'b1, 16'h0800, 16'h0000, 16'h0400);
        wait_idle("t4_done", 60);
        chk_log("t4", 2, 3);

        // stall 5 cycles while waiting on fixu
        post(1, 1'b0, 16'h0200, 16'h0C00, 16'h0100);
        repeat (3) tick();
        enable = 1'b0;
        repeat (5) tick();
        enable = 1'b1;
        wait_idle("t5_done", 50);
        chk("t5_z", 64'(sl(cli_z, 1)), 64'h0700);

        // reset while waiting on fixu
        post(2, 1'b0, 16'h0400, 16'h0400, 16'h0400);
        repeat (3) tick();
        rstn = 1'b0;
        cli_req = '0;
        repeat (2) tick();
        chk("t6_ack", 64'(cli_ack), 64'(0));
        chk("t6_gnt", 64'(gnt_idx), 64'(3));
        chk("t6_busy", 64'(busy), 64'(0));
        rstn = 1'b1;
        tick();
        post(2, 1'b1, 16'h0C00, 16'h0400, 16'h0800);
        wait_idle("t6_done", 50);
        chk("t6_z", 64'(sl(cli_z, 2)), 64'h0400);
        chk("t6_ack_once", 64'(cli_ack), 64'h4);

        // random traffic with random stalls
        for (int t = 0; t < 800; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (cli_req[i] == exp_ack[i] && $urandom_range(0, 3) == 0)
                    post(i, 1'($urandom_range(0, 1)), WID'($urandom), WID'($urandom),
                         ($urandom_range(0, 7) == 0) ? WID'(0) : WID'($urandom_range(1, 16'h3FFF)));
            end
            enable = ($urandom_range(0, 9) != 0);
            tick();
        end
        enable = 1'b1;
        wait_idle("rand_drain", 200);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fixu_arb.md
Name: fixu_arb

Overview:
- Round-robin arbiter and sequencer that shares one fixu (fixed-point mac/sdc unit) among NREQ requesters.
- Each requester posts an operation with a toggle request. The arbiter grants one requester, forwards its operands and fn to fixu over fixu's toggle req/ack handshake, then returns z/overflow to that requester's result registers and toggles its ack.
- Sits between the audio DSP stages and the single fixu instance.

Parameters:
- NREQ, 4, number of requesters (2..8); index width IW = clog2(NREQ), local.
- WID, 16, data width; equals FIXWID of the attached fixu.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low; same net must reset fixu
- enable  in  1  global advance; tie to fixu enable
- cli_req  in  NREQ  per-requester toggle request
- cli_fn  in  NREQ  per-requester op: 0 = a*b+c, 1 = (a-b)/c
- cli_a, cli_b, cli_c  in  NREQ*WID each  packed operands; requester i in slice [i*WID +: WID]
- cli_ack  out  NREQ  per-requester toggle acknowledge
- cli_z  out  NREQ*WID  per-requester registered result
- cli_overflow  out  NREQ  per-requester registered overflow
- fix_req  out  1  toggle request to fixu
- fix_fn  out  1  op to fixu
- fix_a, fix_b, fix_c  out  WID each  operands to fixu
- fix_ack  in  1  toggle ack from fixu
- fix_z  in  WID  fixu result
- fix_overflow  in  1  fixu overflow
- busy  out  1  high while a grant is outstanding
- gnt_idx  out  IW  index of current/last grantee

Behaviour:
- Reset (rstn low at clk edge): state IDLE. cli_ack, cli_z, cli_overflow, fix_req, fix_fn, fix_a/b/c, busy = 0. gnt_idx = NREQ-1, so requester 0 has first priority. ack_seen = 0.
- enable low: every register holds, including the FSM, pointer and ack_seen.
- Pending: pend[i] = cli_req[i] ^ cli_ack[i].
- Requester contract: cli_req is synchronous to clk. Operands/fn are held from the req toggle until the ack toggle. At most one outstanding request per requester.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any pend, select winner = first pending index searching gnt_idx+1, gnt_idx+2, ... modulo NREQ.
  - Latch the winner's a/b/c/fn into fix_a/b/c/fn; gnt_idx <= winner; busy <= 1; go to ISSUE.
  - If no pend, stay in IDLE.
- ISSUE: fix_req <= ~fix_req; go to WAIT. Operands are therefore stable at least one cycle before the toggle.
- WAIT:
  - fix_a/b/c/fn held constant; fixu re-reads fn at completion.
  - On fix_ack != ack_seen: ack_seen <= fix_ack; cli_z[gnt_idx] <= fix_z; cli_overflow[gnt_idx] <= fix_overflow; cli_ack[gnt_idx] toggles; busy <= 0; go to IDLE.
- Overhead: grant to fix_req toggle = 1 cycle. fix_ack toggle to cli_ack toggle = 1 cycle. IDLE to next grant = 1 cycle, so back-to-back service has 2 arbiter cycles plus fixu latency.
- Result registers of requester i change only on completion of i's own grant. Other requesters' results are untouched.
- Requests arriving during ISSUE/WAIT stay pending. They are considered at the next IDLE cycle.
- cli_req[i] toggling again while i is granted is a contract violation. The current result is still delivered and cli_ack[i] toggles once; the pend state afterwards follows the XOR rule.
- Simultaneous pend from all requesters: served strictly round-robin with no starvation; worst-case wait = NREQ-1 services.
- Reset mid-operation: the FSM returns to IDLE and ack_seen = 0. fixu is reset by the same rstn, so its ack = 0 and stays consistent. Any in-flight op is dropped with no cli_ack toggle.
- An fix_ack toggle while in IDLE/ISSUE (not expected): ack_seen is resynced, no client is updated.

Test Plan:
- Reset, then client 0 toggles req with fn=0, a=0x0600 (1.5), b=0x0800 (2.0), c=0x0400 (1.0) -> fix_req toggles 2 cycles after the req toggle; cli_z[0]=0x1000, cli_overflow[0]=0; cli_ack[0] toggles 1 cycle after fix_ack.
- Client 1, fn=1, a=0x0C00, b=0x0400, c=0x0800 -> cli_z[1]=0x0400, overflow 0. Same op with c=0 -> cli_overflow[1]=1.
- All 4 clients toggle req in the same cycle -> grants 0,1,2,3 in order, each cli_ack toggles exactly once, cli_z per-client correct. A repeat round starts at 0.
- After client 2 is served, clients 0 and 3 become pending together -> client 3 is granted first, then client 0.
- Hold enable low for 5 cycles during WAIT -> all outputs frozen; the result after re-enable is identical to the un-stalled run.
- Assert rstn low during WAIT -> all outputs 0, gnt_idx=3. A new request afterwards completes normally with no stale ack toggle.
